// File: rtl/mine_placer_if.sv
// mine_placer_if: request/response bundle between the board logic, the random
// generator and mine_placer.
//   start      request a new board (pulse or level)
//   safe_idx   first-click cell, latched when start is accepted
//   rnd        random byte from the generator, new value every clock
//   rd_idx     bitmap query index
//   busy       placement in progress
//   done       placement finished, bitmap stable
//   mine_count mines placed so far
//   mine_map   bit i set = cell i holds a mine
//   rd_mine    mine_map[rd_idx], 0 when rd_idx is off the board
// Modports: master = board side (drives requests), slave = mine_placer.
interface mine_placer_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    localparam int CELLS = ROWS * COLS;

    logic             start;
    logic [7:0]       safe_idx;
    logic [7:0]       rnd;
    logic [7:0]       rd_idx;
    logic             busy;
    logic             done;
    logic [8:0]       mine_count;
    logic [CELLS-1:0] mine_map;
    logic             rd_mine;

    modport master (
        output start, safe_idx, rnd, rd_idx,
        input  busy, done, mine_count, mine_map, rd_mine
    );

    modport slave (
        input  start, safe_idx, rnd, rd_idx,
        output busy, done, mine_count, mine_map, rd_mine
    );
endinterface

// File: rtl/mine_placer.sv
// mine_placer: builds a bitmap of exactly MINES mines from a pseudo-random
// byte stream, rejecting off-board, duplicate and safe-cell draws.
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    mine_placer_if.slave (start, safe_idx, rnd, rd_idx in;
//          busy, done, mine_count, mine_map, rd_mine out)
// Optional build macro SAFE_ZONE_EN: when defined, the whole 3x3
// neighbourhood of the safe cell (clipped at the board edges) is kept
// mine-free; otherwise only the safe cell itself is excluded.
module mine_placer #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int MINES = 40
) (
    input  logic          clk,
    input  logic          reset,
    mine_placer_if.slave  bus
);
    localparam int CELLS = ROWS * COLS;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [8:0] CELLS9 = 9'(CELLS);
    localparam logic [8:0] MINES9 = 9'(MINES);

    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

    state_t           state, state_nxt;
    logic [CELLS-1:0] mine_map;
    logic [8:0]       mine_count;
    logic [7:0]       safe;
    logic [8:0]       count_inc;
    logic             in_range;
    logic             is_free;
    logic             excluded;
    logic             accept;
    logic             busy;
    logic             done;

`ifdef SAFE_ZONE_EN
    localparam logic [8:0] COLS9 = 9'(COLS);

    logic [8:0] safe_row, safe_col;
    logic       safe_ok;
    logic [8:0] cand_row, cand_col;
    logic       row_near, col_near;

    // Candidate row/col use a constant divisor; the safe cell's row/col are
    // registered once in CLEAR so PLACE only compares.
    always_comb begin
        cand_row = {1'b0, bus.rnd} / COLS9;
        cand_col = {1'b0, bus.rnd} % COLS9;
        row_near = (cand_row == safe_row) || (cand_row + 9'd1 == safe_row) ||
                   (cand_row == safe_row + 9'd1);
        col_near = (cand_col == safe_col) || (cand_col + 9'd1 == safe_col) ||
                   (cand_col == safe_col + 9'd1);
        // An off-board safe index must exclude nothing, even though its
        // computed row may sit just below the last board row.
        excluded = safe_ok && row_near && col_near;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            safe_row <= '0;
            safe_col <= '0;
            safe_ok  <= 1'b0;
        end else if (state == CLEAR) begin
            safe_row <= {1'b0, safe} / COLS9;
            safe_col <= {1'b0, safe} % COLS9;
            safe_ok  <= ({1'b0, safe} < CELLS9);
        end
    end
`else
    always_comb begin
        excluded = (bus.rnd == safe);
    end
`endif

    always_comb begin
        in_range  = ({1'b0, bus.rnd} < CELLS9);
        is_free   = in_range && !mine_map[bus.rnd[IW-1:0]];
        accept    = (MINES9 != '0) && is_free && !excluded;
        count_inc = mine_count + 9'd1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = CLEAR;
            CLEAR:      state_nxt = PLACE;
            PLACE: begin
                if (MINES9 == '0)                          state_nxt = DONE;
                else if (accept && (count_inc == MINES9))  state_nxt = DONE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath: safe latch, bitmap and counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            mine_map   <= '0;
            mine_count <= '0;
            safe       <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) safe <= bus.safe_idx;
                CLEAR: begin
                    mine_map   <= '0;
                    mine_count <= '0;
                end
                PLACE: if (accept) begin
                    mine_map[bus.rnd[IW-1:0]] <= 1'b1;
                    mine_count                <= count_inc;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy = (state == CLEAR) || (state == PLACE);
        done = (state == DONE);
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.mine_count = mine_count;
    assign bus.mine_map   = mine_map;
    assign bus.rd_mine    = ({1'b0, bus.rd_idx} < CELLS9) ? mine_map[bus.rd_idx[IW-1:0]] : 1'b0;
endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
Consumer of the 8-bit pseudo-random stream from the board's random generator. On a start request it draws random bytes, maps them to board cell indices, rejects invalid or duplicate draws, and builds a mine bitmap of exactly MINES mines. The board logic reads the bitmap after done is asserted; the first-clicked cell is always mine-free.

Parameters:
ROWS, 16, board rows; ROWS*COLS must be <= 256
COLS, 16, board columns
MINES, 40, mines to place; must be <= ROWS*COLS-1 (<= ROWS*COLS-9 with SAFE_ZONE_EN)
CELLS, ROWS*COLS, derived localparam; not overridable

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  request a new board; single-cycle pulse or level
safe_idx  in  8  first-click cell index (row*COLS+col); latched when start is accepted
rnd  in  8  random byte from the generator; new value every clock
busy  out  1  high while placement is in progress
done  out  1  high from placement completion until the next accepted start
mine_count  out  9  mines placed so far
mine_map  out  CELLS  bit i = 1 means cell i holds a mine
rd_idx  in  8  query index
rd_mine  out  1  combinational mine_map[rd_idx]; 0 if rd_idx >= CELLS

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, mine_map=0, mine_count=0, busy=0, done=0, safe register=0. Reset mid-placement aborts immediately and discards the partial map.
- States: IDLE, CLEAR, PLACE, DONE.
- IDLE/DONE: when start==1 at an edge, latch safe_idx and go to CLEAR. The DONE->CLEAR transition drops done on that same edge.
- CLEAR: one cycle. mine_map<=0, mine_count<=0, busy=1. Next state is PLACE.
- PLACE: at each edge, sample rnd and accept it when all of the following hold:
  - rnd < CELLS
  - rnd != latched safe index
  - mine_map[rnd]==0
  - On accept: set mine_map[rnd], increment mine_count. If the incremented count equals MINES, go to DONE.
  - On reject: no change.
- DONE: busy=0, done=1; mine_map is stable.
- Timing: start at edge k. CLEAR occupies k..k+1. The first rnd sample is at edge k+2. done reads 1 in the cycle after the accepting edge.
- start while busy is ignored.
- MINES==0: PLACE exits to DONE on its first edge without sampling.
- Termination bound: the generator's sequence visits all 256 values per period. Any 256 consecutive draws therefore contain every free cell, so PLACE lasts at most 256*MINES cycles.
- safe_idx >= CELLS is legal; it excludes nothing.
- mine_count never exceeds MINES.

Optional Feature:
SAFE_ZONE_EN
- Defined: the rejection set is the full 3x3 neighbourhood of the latched safe cell, clipped at board edges with no wrap between rows. row=safe/COLS, col=safe%COLS are computed once in CLEAR. A candidate is rejected if |r-row|<=1 and |c-col|<=1.
- Undefined: only the safe cell itself is excluded, and no divider logic is present.

Test Plan:
- Reset mid-PLACE (ROWS=COLS=4, MINES=3, one mine placed, reset=0 for 1 cycle) -> mine_map=0, mine_count=0, busy=0, done=0, state IDLE; no further map writes.
- ROWS=COLS=4, MINES=3, safe_idx=7, start at edge 0, rnd at edges 2..7 = 20,5,5,7,0,15 -> 20 rejected (out of range), second 5 rejected (duplicate), 7 rejected (safe), 15 accepted at edge 7. Result: mine_map=16'h8021, mine_count=3, done=1 from edge 8, busy 1 during edges 1..7.
- Default 16x16, MINES=40, rnd driven by the real generator, 1000 starts with random safe_idx -> every run gives popcount(mine_map)=40, mine_map[safe_idx]=0, completion <= 10240 cycles.
- start pulsed while busy, then again in DONE -> first pulse ignored. Second pulse clears done on the same edge and yields a fresh map with mine_count back to 0 before refilling.
- SAFE_ZONE_EN, 4x4, MINES=3, safe_idx=0, rnd=1,4,5,2,8,10 -> 1,4,5 rejected; 2,8,10 accepted; mine_map=16'h0504.
- MINES=0 -> done=1 two cycles after the CLEAR cycle, mine_map=0; rd_idx=200 on a 4x4 board -> rd_mine=0.
